// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, command bytes and row addressing for the character LCD controller
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_FSET,
    S_DISP,
    S_ENTRY,
    S_CLEAR,
    S_IDLE,
    S_ADDR,
    S_CHAR
  } lcd_state_t;

  localparam logic [7:0] CMD_FSET_2L   = 8'h38;
  localparam logic [7:0] CMD_FSET_1L   = 8'h30;
  localparam logic [7:0] CMD_DISP      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CHAR_BLANK    = 8'h20;

  // DDRAM start address of each display row
  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - divides clk down to a one-cycle LCD tick strobe
module lcd_tick_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // free-running divider, wraps at CLK_DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/lcd_char_ctrl.sv
// rtl/lcd_char_ctrl.sv - HD44780-class controller: init sequence plus buffer-driven panel redraw
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_DIV      = 5,
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int PWRUP_TICKS  = 70,
  parameter int CMD_WAIT     = 2,
  parameter int CLEAR_WAIT   = 200,
  parameter int AUTO_REFRESH = 0,
  localparam int AW          = $clog2(ROWS * COLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          busy,
  output logic          init_done,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic [7:0]    lcd_data
);

  localparam int NCELL = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CWD   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CWD-1:0] COL_LAST = CWD'(COLS - 1);
  localparam logic [15:0]    PWR_LAST = 16'((PWRUP_TICKS > 0) ? PWRUP_TICKS - 1 : 0);
  localparam logic [15:0]    CMD_LAST = 16'(CMD_WAIT + 2);
  localparam logic [15:0]    CLR_LAST = 16'(CLEAR_WAIT + 2);
  localparam logic [15:0]    CHR_LAST = 16'd2;
  localparam logic [7:0]     FSET_VAL = (ROWS == 1) ? CMD_FSET_1L : CMD_FSET_2L;

  logic             tick;
  lcd_state_t       state, state_nx, byte_next;
  logic [15:0]      tcnt, tcnt_nx, byte_last;
  logic [RW-1:0]    row, row_nx;
  logic [CWD-1:0]   col, col_nx;
  logic             e_nx, rs_nx, init_nx, byte_rs;
  logic [7:0]       data_nx, byte_val;
  logic             dirty, dirty_clr, refresh, wr_ok;
  logic [AW-1:0]    rd_idx;
  logic [7:0]       buf_mem [NCELL];

  lcd_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign lcd_rw  = 1'b0;
  assign wr_ok   = wr_en && (int'(wr_addr) < NCELL);
  assign refresh = dirty || (AUTO_REFRESH != 0);
  assign rd_idx  = AW'(int'(row) * COLS + int'(col));

  // character buffer and dirty flag; a write in the same cycle as a clear keeps dirty set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCELL; i++) buf_mem[i] <= CHAR_BLANK;
      dirty <= 1'b1;
    end else begin
      if (wr_ok) buf_mem[wr_addr] <= wr_data;
      if (wr_ok)          dirty <= 1'b1;
      else if (dirty_clr) dirty <= 1'b0;
    end
  end

  // FSM state, tick counter, cursor and registered LCD pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_PWRUP;
      tcnt      <= '0;
      row       <= '0;
      col       <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      row       <= row_nx;
      col       <= col_nx;
      lcd_e     <= e_nx;
      lcd_rs    <= rs_nx;
      lcd_data  <= data_nx;
      init_done <= init_nx;
      busy      <= (state_nx != S_IDLE);
    end
  end

  // next state: every byte state runs T0/T1/T2 then its wait ticks, last tick moves on
  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt;
    row_nx    = row;
    col_nx    = col;
    e_nx      = lcd_e;
    rs_nx     = lcd_rs;
    data_nx   = lcd_data;
    init_nx   = init_done;
    dirty_clr = 1'b0;
    byte_rs   = 1'b0;
    byte_val  = 8'h00;
    byte_last = CMD_LAST;
    byte_next = state;

    case (state)
      S_FSET:  begin byte_val = FSET_VAL;  byte_next = S_DISP;  end
      S_DISP:  begin byte_val = CMD_DISP;  byte_next = S_ENTRY; end
      S_ENTRY: begin byte_val = CMD_ENTRY; byte_next = S_CLEAR; end
      S_CLEAR: begin byte_val = CMD_CLEAR; byte_last = CLR_LAST; byte_next = S_IDLE; end
      S_ADDR:  begin byte_val = CMD_SET_DDRAM | row_base(2'(row)); byte_next = S_CHAR; end
      S_CHAR:  begin byte_rs = 1'b1; byte_val = buf_mem[rd_idx]; byte_last = CHR_LAST; end
      default: ;
    endcase

    if (state == S_PWRUP) begin
      if (tick) begin
        if (tcnt == PWR_LAST) begin
          state_nx = S_FSET;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
    end else if (state == S_IDLE) begin
      if (refresh) begin
        state_nx  = S_ADDR;
        tcnt_nx   = '0;
        row_nx    = '0;
        col_nx    = '0;
        dirty_clr = 1'b1;
      end
    end else if (tick) begin
      if (tcnt == 16'd0) begin
        e_nx    = 1'b0;
        rs_nx   = byte_rs;
        data_nx = byte_val;
      end else if (tcnt == 16'd1) begin
        e_nx = 1'b1;
      end else if (tcnt == 16'd2) begin
        e_nx = 1'b0;
      end
      if (tcnt == byte_last) begin
        tcnt_nx  = '0;
        state_nx = byte_next;
        if (state == S_CLEAR) init_nx = 1'b1;
        if (state == S_CHAR) begin
          if (col == COL_LAST) begin
            col_nx = '0;
            if (row == ROW_LAST) begin
              // a pending change starts the next frame without dropping busy
              if (refresh) begin
                state_nx  = S_ADDR;
                row_nx    = '0;
                dirty_clr = 1'b1;
              end else begin
                state_nx = S_IDLE;
              end
            end else begin
              row_nx   = row + 1'b1;
              state_nx = S_ADDR;
            end
          end else begin
            col_nx = col + 1'b1;
          end
        end
      end else begin
        tcnt_nx = tcnt + 1'b1;
      end
    end
  end

endmodule
